// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access encodings, FSM states, counter width.
// No logic; constants and enums only.
// Imported by the responder top and its lane-alignment helper.
package dmem_pkg;

    // Width of the wait-state counter; covers LATENCY values up to 15.
    localparam int LAT_W = 4;

    // Access control encodings, identical to the load/store funct3 field.
    typedef enum logic [2:0] {
        ACC_B  = 3'b000,
        ACC_H  = 3'b001,
        ACC_W  = 3'b010,
        ACC_BU = 3'b100,
        ACC_HU = 3'b101
    } access_t;

    // Responder transaction states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store requester and the memory responder.
// Pure wiring, no latency.
// valid/ready on both the request and the response channel.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Requester side (CPU datapath).
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder side (memory).
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store merge, load extraction with sign/zero extension, alignment/legality flag.
// Purely combinational, zero latency.
// No handshake; the caller decides when the results are used.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  lane,
    input  logic        is_write,
    input  logic [31:0] stored,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_word,
    output logic        bad
);

    logic [4:0]  shamt;
    logic [31:0] rd_shifted;
    logic [31:0] wd_shifted;

    // Bring the addressed lane down to bit 0 for loads; push low-aligned store data up to its lane.
    assign shamt      = {lane, 3'b000};
    assign rd_shifted = stored >> shamt;
    assign wd_shifted = wdata << shamt;

    // Decode access size, check alignment/legality, and extend the loaded value.
    always_comb begin
        byte_en   = 4'b0000;
        load_word = 32'h0;
        bad       = 1'b0;
        case (ctrl)
            ACC_B: begin
                byte_en   = 4'b0001 << lane;
                load_word = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            end
            ACC_BU: begin
                byte_en   = 4'b0001 << lane;
                load_word = {24'h0, rd_shifted[7:0]};
                bad       = is_write;
            end
            ACC_H: begin
                byte_en   = 4'b0011 << lane;
                load_word = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
                bad       = lane[0];
            end
            ACC_HU: begin
                byte_en   = 4'b0011 << lane;
                load_word = {16'h0, rd_shifted[15:0]};
                bad       = lane[0] | is_write;
            end
            ACC_W: begin
                byte_en   = 4'b1111;
                load_word = rd_shifted;
                bad       = (lane != 2'b00);
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        // A rejected access must never touch storage.
        if (bad) begin
            byte_en = 4'b0000;
        end
    end

    // Replace only the enabled byte lanes of the stored word.
    always_comb begin
        store_word = stored;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                store_word[8*i +: 8] = wd_shifted[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressed data memory behind a valid/ready request/response handshake.
// Accept-to-response is LATENCY+1 cycles; one transaction per LATENCY+2 cycles at best.
// Accepts only in IDLE; holds the response stable until rsp_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    state_t             state_q,     state_d;
    logic [LAT_W-1:0]   cnt_q,       cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q,   rsp_err_d;
    logic               wr_q,        wr_d;
    logic [31:0]        addr_q,      addr_d;
    logic [31:0]        wdata_q,     wdata_d;
    logic [2:0]         ctrl_q,      ctrl_d;

    logic [31:0]            mem [DEPTH];
    logic [ADDR_WIDTH-3:0]  word_idx;
    logic [31:0]            stored_word;
    logic                   out_of_range;
    logic [3:0]             byte_en;
    logic [31:0]            store_word;
    logic [31:0]            load_word;
    logic                   align_bad;
    logic                   access_bad;
    logic                   mem_we;

    // Address split: anything above the implemented range is rejected, never aliased.
    assign word_idx     = addr_q[ADDR_WIDTH-1:2];
    assign out_of_range = |addr_q[31:ADDR_WIDTH];
    assign stored_word  = mem[word_idx];

    dmem_lane_align u_lane_align (
        .ctrl       (ctrl_q),
        .lane       (addr_q[1:0]),
        .is_write   (wr_q),
        .stored     (stored_word),
        .wdata      (wdata_q),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_word  (load_word),
        .bad        (align_bad)
    );

    assign access_bad = align_bad | out_of_range;

    // Next-state, capture and response computation; all outputs come from flops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ctrl_d      = ctrl_q;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    wr_d        = bus.req_write;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    ctrl_d      = bus.req_ctrl;
                    cnt_d       = LAT_W'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // The access happens on this edge; the response is registered alongside it.
                    mem_we      = wr_q & ~access_bad;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = access_bad;
                    rsp_rdata_d = (access_bad || wr_q) ? 32'h0 : load_word;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    // Raise ready now so IDLE can accept in its very first cycle.
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Control and response registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            ctrl_q      <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ctrl_q      <= ctrl_d;
        end
    end

    // Storage array: contents survive reset, written only on a clean store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= store_word;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=1 instance.
// Stimulus goes to whichever instance 'sel' picks; expected values are hand-computed constants.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sel         = 1'b0;
    logic        t_valid     = 1'b0;
    logic        t_write     = 1'b0;
    logic [31:0] t_addr      = 32'h0;
    logic [31:0] t_wdata     = 32'h0;
    logic [2:0]  t_ctrl      = 3'b000;
    logic        t_rsp_ready = 1'b0;

    dmem_responder_if bus0();
    dmem_responder_if bus1();

    assign bus0.req_valid = t_valid & ~sel;
    assign bus1.req_valid = t_valid & sel;
    assign bus0.req_write = t_write;
    assign bus1.req_write = t_write;
    assign bus0.req_addr  = t_addr;
    assign bus1.req_addr  = t_addr;
    assign bus0.req_wdata = t_wdata;
    assign bus1.req_wdata = t_wdata;
    assign bus0.req_ctrl  = t_ctrl;
    assign bus1.req_ctrl  = t_ctrl;
    assign bus0.rsp_ready = t_rsp_ready & ~sel;
    assign bus1.rsp_ready = t_rsp_ready & sel;

    wire        m_req_ready = sel ? bus1.req_ready : bus0.req_ready;
    wire        m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
    wire [31:0] m_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    wire        m_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;

    dmem_responder #(.ADDR_WIDTH(17), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.ADDR_WIDTH(17), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // One complete transaction; lat = negedges from acceptance edge to first rsp_valid (-1 on timeout).
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                        output logic [31:0] rd, output logic e, output int lat, output int rsp_cyc);
        int n;
        rd = 32'h0; e = 1'b0; lat = -1; rsp_cyc = 0;
        @(negedge clk);
        t_valid = 1'b1; t_write = w; t_addr = a; t_wdata = d; t_ctrl = c;
        n = 0;
        while (!m_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_req_ready) begin
            t_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 t_valid = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (m_rsp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) return;
        rd = m_rsp_rdata; e = m_rsp_err; rsp_cyc = cyc;
        t_rsp_ready = 1'b1;
        @(posedge clk);
        #1 t_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", bus0.req_ready); end
        checks++; if (bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", bus0.rsp_rdata); end
        checks++; if (bus0.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", bus0.rsp_err); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus0.req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat, rc;
        sel = 1'b0;
        xact(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, rd, e, lat, rc);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
        checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL sw_rsp: got %h/%b want 0/0", rd, e); end
        xact(1'b0, 32'h100, 32'h0, 3'b010, rd, e, lat, rc);
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", e); end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic e; int lat, rc;
        sel = 1'b0;
        xact(1'b1, 32'h100, 32'h11223344, 3'b010, rd, e, lat, rc);
        xact(1'b1, 32'h103, 32'h00000080, 3'b000, rd, e, lat, rc);
        checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_rsp: got %h/%b want 0/0", rd, e); end
        xact(1'b0, 32'h100, 32'h0, 3'b010, rd, e, lat, rc);
        checks++; if (rd !== 32'h80223344) begin errors++; $display("FAIL sb_merge: got %h want 80223344", rd); end
        xact(1'b0, 32'h103, 32'h0, 3'b000, rd, e, lat, rc);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h want ffffff80", rd); end
        xact(1'b0, 32'h103, 32'h0, 3'b100, rd, e, lat, rc);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", rd); end
        xact(1'b0, 32'h102, 32'h0, 3'b001, rd, e, lat, rc);
        checks++; if (rd !== 32'hFFFF8022) begin errors++; $display("FAIL lh: got %h want ffff8022", rd); end
        xact(1'b0, 32'h102, 32'h0, 3'b101, rd, e, lat, rc);
        checks++; if (rd !== 32'h00008022) begin errors++; $display("FAIL lhu: got %h want 00008022", rd); end
        xact(1'b0, 32'h100, 32'h0, 3'b001, rd, e, lat, rc);
        checks++; if (rd !== 32'h00003344) begin errors++; $display("FAIL lh_low: got %h want 00003344", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat, rc;
        sel = 1'b0;
        xact(1'b0, 32'h102, 32'h0, 3'b010, rd, e, lat, rc);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misalign: got %h/%b want 0/1", rd, e); end
        xact(1'b1, 32'h101, 32'h0000BEEF, 3'b001, rd, e, lat, rc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL sh_misalign: got err %b want 1", e); end
        xact(1'b0, 32'h100, 32'h0, 3'b011, rd, e, lat, rc);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ctrl_011: got %h/%b want 0/1", rd, e); end
        xact(1'b0, 32'h100, 32'h0, 3'b111, rd, e, lat, rc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ctrl_111: got err %b want 1", e); end
        xact(1'b0, 32'h0002_0000, 32'h0, 3'b010, rd, e, lat, rc);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL out_of_range: got %h/%b want 0/1", rd, e); end
        xact(1'b1, 32'h0002_0100, 32'h12345678, 3'b010, rd, e, lat, rc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL sw_out_of_range: got err %b want 1", e); end
        xact(1'b1, 32'h100, 32'h000000FF, 3'b100, rd, e, lat, rc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL sbu: got err %b want 1", e); end
        xact(1'b0, 32'h100, 32'h0, 3'b010, rd, e, lat, rc);
        checks++; if (rd !== 32'h80223344 || e !== 1'b0) begin errors++; $display("FAIL err_mem_unchanged: got %h/%b want 80223344/0", rd, e); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held; int n; int lat; logic [31:0] rd; logic e; int rc;
        sel = 1'b0;
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b0; t_addr = 32'h100; t_ctrl = 3'b010;
        n = 0;
        while (!m_req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        // A second request stays presented while the first is outstanding.
        #1 t_addr = 32'h103; t_ctrl = 3'b100;
        n = 0;
        while (!m_rsp_valid && n < 50) begin @(negedge clk); n++; end
        checks++; if (m_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout: got %b want 1", m_rsp_valid); end
        held = 32'h80223344;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++; if (m_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b want 1", k, m_rsp_valid); end
            checks++; if (m_rsp_rdata !== held) begin errors++; $display("FAIL bp_rdata_%0d: got %h want %h", k, m_rsp_rdata, held); end
            checks++; if (m_req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready_%0d: got %b want 0", k, m_req_ready); end
        end
        t_rsp_ready = 1'b1;
        @(posedge clk);
        #1 t_rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", m_rsp_valid); end
        checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", m_req_ready); end
        @(posedge clk);
        #1 t_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (m_rsp_valid) begin lat = i; break; end
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL bp_second_latency: got %0d want 3", lat); end
        checks++; if (m_rsp_rdata !== 32'h00000080) begin errors++; $display("FAIL bp_second_data: got %h want 00000080", m_rsp_rdata); end
        t_rsp_ready = 1'b1;
        @(posedge clk);
        #1 t_rsp_ready = 1'b0;
        xact(1'b0, 32'h100, 32'h0, 3'b010, rd, e, lat, rc);
    endtask

    task automatic test_reset_in_resp();
        int n;
        sel = 1'b0;
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b0; t_addr = 32'h100; t_ctrl = 3'b010;
        n = 0;
        while (!m_req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 t_valid = 1'b0;
        n = 0;
        while (!m_rsp_valid && n < 50) begin @(negedge clk); n++; end
        checks++; if (m_rsp_rdata !== 32'h80223344) begin errors++; $display("FAIL resp_before_rst: got %h want 80223344", m_rsp_rdata); end
        rst = 1'b0;
        #1;
        checks++; if (m_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", m_rsp_valid); end
        checks++; if (m_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", m_rsp_rdata); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd; logic e; int lat, rc, n;
        sel = 1'b0;
        xact(1'b1, 32'h200, 32'h01234567, 3'b010, rd, e, lat, rc);
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b1; t_addr = 32'h200; t_wdata = 32'hCAFEF00D; t_ctrl = 3'b010;
        n = 0;
        while (!m_req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 t_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (m_req_ready !== 1'b0 || m_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs: got ready %b valid %b want 0 0", m_req_ready, m_rsp_valid); end
        checks++; if (m_rsp_rdata !== 32'h0 || m_rsp_err !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp: got %h/%b want 0/0", m_rsp_rdata, m_rsp_err); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 32'h200, 32'h0, 3'b010, rd, e, lat, rc);
        checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL mid_rst_no_write: got %h want 01234567", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat, rc0, rc1, rc2;
        sel = 1'b0;
        xact(1'b0, 32'h100, 32'h0, 3'b010, rd, e, lat, rc0);
        xact(1'b0, 32'h200, 32'h0, 3'b010, rd, e, lat, rc1);
        checks++; if (rc1 - rc0 !== 4) begin errors++; $display("FAIL b2b_lat2_period: got %0d want 4", rc1 - rc0); end
        sel = 1'b1;
        xact(1'b1, 32'h40, 32'hA5A50F0F, 3'b010, rd, e, lat, rc0);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lat1_sw_latency: got %0d want 2", lat); end
        xact(1'b0, 32'h40, 32'h0, 3'b010, rd, e, lat, rc0);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lat1_lw_latency: got %0d want 2", lat); end
        checks++; if (rd !== 32'hA5A50F0F) begin errors++; $display("FAIL lat1_lw_data: got %h want a5a50f0f", rd); end
        xact(1'b0, 32'h41, 32'h0, 3'b100, rd, e, lat, rc1);
        checks++; if (rd !== 32'h0000000F) begin errors++; $display("FAIL lat1_lbu: got %h want 0000000f", rd); end
        xact(1'b0, 32'h42, 32'h0, 3'b001, rd, e, lat, rc2);
        checks++; if (rd !== 32'hFFFFA5A5) begin errors++; $display("FAIL lat1_lh: got %h want ffffa5a5", rd); end
        checks++; if (rc1 - rc0 !== 3 || rc2 - rc1 !== 3) begin errors++; $display("FAIL b2b_lat1_period: got %0d,%0d want 3,3", rc1 - rc0, rc2 - rc1); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_in_resp();
        test_reset_mid_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the load/store interface the CPU datapath drives: address, write data, 3-bit access control (funct3), read/write intent.
- Adds a valid/ready request/response handshake with configurable wait states, so multi-cycle datapaths can use slower memory.
- Owns a little-endian byte-addressed store, does byte-lane merge on stores and sign/zero extension on loads, and flags misaligned, out-of-range or illegal accesses.

Parameters:
- ADDR_WIDTH, 17, byte-address bits implemented; storage is 2^ADDR_WIDTH bytes held as 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 2, wait cycles between request acceptance and response (legal 1..15).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, low-aligned (byte in [7:0], half in [15:0])
- req_ctrl  input  3  access control = funct3
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  access rejected

Behaviour:
- Reset is asynchronous and active-low (rst = 0); release is synchronous to clk.
- In reset: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0. Storage contents are not reset.
- State machine IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: req_ready = 1. On req_valid && req_ready, capture write, addr, wdata and ctrl; load counter with LATENCY-1; go to WAIT. No combinational path from req_* to rsp_*.
  - WAIT: req_ready = 0. Counter decrements each cycle. When counter == 0, perform the access at that edge and go to RESP with rsp_valid = 1.
  - RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready = 1, then return to IDLE. rsp_ready is ignored in every other state.
- Latency: acceptance edge to first rsp_valid cycle is exactly LATENCY+1 cycles. Back-to-back throughput is one transaction per LATENCY+2 cycles minimum.
- req_ctrl decode:
  - 000 = byte, signed on load
  - 001 = half, signed on load
  - 010 = word
  - 100 = byte unsigned
  - 101 = half unsigned
  - 011, 110, 111 = illegal
  - 100 and 101 with req_write = 1 are also illegal.
- Error conditions: illegal ctrl; half access with addr[0] = 1; word access with addr[1:0] != 0; any addr[31:ADDR_WIDTH] nonzero.
- On error: rsp_err = 1, rsp_rdata = 0, storage unchanged.
- Store: only the addressed byte lanes are written, at the WAIT-exit edge. Word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0].
- Load: data is extracted from the lane and sign- or zero-extended to 32 bits.
- Store response: rsp_rdata = 0, rsp_err = 0.
- Reset mid-transaction: the pending access is dropped. A store in WAIT does not write; state is IDLE after reset.
- req_valid asserted outside IDLE is not accepted. The requester holds the request until req_ready is high.
- No internal wrap-around: out-of-range addresses error rather than alias.

Decomposition:
- dmem_pkg:
  - access_t enum (ACC_B = 3'b000, ACC_H, ACC_W, ACC_BU = 3'b100, ACC_HU)
  - state_t enum (S_IDLE, S_WAIT, S_RESP)
  - localparam LAT_W = 4
- Sub-module dmem_lane_align, purely combinational:
  - inputs: ctrl, addr[1:0], stored word, wdata
  - outputs: 4-bit byte enable, merged store word, extended load word, misalign/illegal flag
- Keeps the FSM module focused on handshake and timing.

Test Plan:
- Store/load word, LATENCY = 2: SW 0xDEADBEEF @0x100, then LW @0x100 -> rsp_valid 3 cycles after accept, rdata = 0xDEADBEEF, err = 0.
- Byte lanes and extension: SB 0x80 @0x103 over 0x11223344, then LW @0x100 -> 0x80223344; LB @0x103 -> 0xFFFFFF80; LBU -> 0x00000080; LH @0x102 -> 0xFFFF8022; LHU -> 0x00008022.
- Errors:
  - LW @0x102 -> err = 1, rdata = 0.
  - SH @0x101 -> err = 1 and memory unchanged.
  - ctrl = 3'b011 -> err = 1.
  - addr 0x0002_0000 -> err = 1.
  - SBU (ctrl 100, write) -> err = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_* stable, req_ready = 0; a new req_valid is not accepted until 1 cycle after rsp_ready = 1.
- Reset mid-store: accept SW 0xCAFEF00D @0x200, drop rst during WAIT -> outputs at reset values immediately; after release, LW @0x200 returns the old contents.
- LATENCY = 1 build: LW accept-to-rsp_valid = 2 cycles; back-to-back requests complete every 3 cycles.
